cordic_vectoring_engine: RTL and testbench

Iterative vectoring-mode CORDIC. Takes a Cartesian vector (x, y) in any quadrant and produces its magnitude and its angle, in the same 32-bit angle format used by the rotation path. It is the inverse of the rotation-mode front end:
- Input quadrant is folded into the right half-plane before iterating.
- The fold is undone by adding ±90° to the angle accumulator.

It sits on the output side of the CORDIC datapath and feeds the atan2/magnitude consumers through a valid/ready handshake.

---
 rtl/cordic_vectoring_engine_pkg.sv | 65 ++++++
 rtl/cordic_vectoring_engine_if.sv | 24 ++
 rtl/cordic_vectoring_engine_precorrect.sv | 33 +++
 rtl/cordic_vectoring_engine.sv | 150 +++++++++++++++
 tb/tb_cordic_vectoring_engine.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cordic_vectoring_engine_pkg.sv
// Shared constants for the vectoring CORDIC: angle format, gain constant,
// FSM state encodings and the arctangent table.
// Angle format: 45 deg = 0x10000000, 90 deg = 0x20000000, 180 deg = 0x40000000.
// Optional gain compensation is selected with the macro CORDIC_GAIN_COMP_EN.
package cordic_vectoring_engine_pkg;

   localparam logic [31:0] ANG_90     = 32'h2000_0000;
   localparam logic [31:0] ANG_NEG_90 = 32'hE000_0000;
   localparam logic [31:0] ANG_180    = 32'h4000_0000;

   // 1/An for the CORDIC gain, unsigned Q1.31 (0.6072529350)
   localparam logic [31:0] CORDIC_K   = 32'h4DBA_76D4;

   localparam int ATAN_ENTRIES = 30;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_ITER = 3'd2,
`ifdef CORDIC_GAIN_COMP_EN
      ST_GAIN = 3'd3,
`endif
      ST_DONE = 3'd4
   } state_t;

   // atan(2^-i) expressed in angle LSBs; indices past the table return 0
   function automatic logic [31:0] atan_lut(input logic [4:0] idx);
      logic [31:0] val;
      case (idx)
         5'd0:    val = 32'h1000_0000;
         5'd1:    val = 32'h0972_028E;
         5'd2:    val = 32'h04FD_9C2E;
         5'd3:    val = 32'h0288_88EA;
         5'd4:    val = 32'h0145_86A2;
         5'd5:    val = 32'h00A2_EBF1;
         5'd6:    val = 32'h0051_7B0F;
         5'd7:    val = 32'h0028_BE2B;
         5'd8:    val = 32'h0014_5F2A;
         5'd9:    val = 32'h000A_2F98;
         5'd10:   val = 32'h0005_17CC;
         5'd11:   val = 32'h0002_8BE6;
         5'd12:   val = 32'h0001_45F3;
         5'd13:   val = 32'h0000_A2FA;
         5'd14:   val = 32'h0000_517D;
         5'd15:   val = 32'h0000_28BE;
         5'd16:   val = 32'h0000_145F;
         5'd17:   val = 32'h0000_0A30;
         5'd18:   val = 32'h0000_0518;
         5'd19:   val = 32'h0000_028C;
         5'd20:   val = 32'h0000_0146;
         5'd21:   val = 32'h0000_00A3;
         5'd22:   val = 32'h0000_0051;
         5'd23:   val = 32'h0000_0029;
         5'd24:   val = 32'h0000_0014;
         5'd25:   val = 32'h0000_000A;
         5'd26:   val = 32'h0000_0005;
         5'd27:   val = 32'h0000_0003;
         5'd28:   val = 32'h0000_0001;
         5'd29:   val = 32'h0000_0001;
         default: val = 32'h0000_0000;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/cordic_vectoring_engine_if.sv
// Handshake bundle between the vectoring engine and its producer/consumer.
// The master side supplies vectors and accepts results; the slave is the engine.
interface cordic_vectoring_engine_if;

   logic [31:0] x_in;
   logic [31:0] y_in;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] mag_out;
   logic [31:0] angle_out;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output x_in, y_in, in_valid, out_ready,
      input  in_ready, mag_out, angle_out, out_valid
   );

   modport slave (
      input  x_in, y_in, in_valid, out_ready,
      output in_ready, mag_out, angle_out, out_valid
   );

endinterface

// File: rtl/cordic_vectoring_engine_precorrect.sv
// Quadrant fold: rotates a left-half-plane vector by +/-90 deg into the right
// half-plane and reports the angle already consumed. Purely combinational.
module cordic_vec_precorrect
   import cordic_vectoring_engine_pkg::*;
#(
   parameter int IW = 34
) (
   input  logic signed [IW-1:0] x,
   input  logic signed [IW-1:0] y,
   output logic signed [IW-1:0] x_fold,
   output logic signed [IW-1:0] y_fold,
   output logic        [31:0]   z_init
);

   // y >= 0 (including y = 0) folds by -90 deg so x<0, y=0 ends at +180 deg
   always_comb begin
      x_fold = x;
      y_fold = y;
      z_init = '0;
      if (x[IW-1]) begin
         if (!y[IW-1]) begin
            x_fold = y;
            y_fold = -x;
            z_init = ANG_90;
         end else begin
            x_fold = -y;
            y_fold = x;
            z_init = ANG_NEG_90;
         end
      end
   end

endmodule

// File: rtl/cordic_vectoring_engine.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (magnitude, angle).
// One vector in flight; quadrant fold, N_ITER micro-rotations, then result
// held on a valid/ready output.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales the magnitude by
// 1/An; otherwise mag_out carries the raw CORDIC gain (~1.6468).
module cordic_vectoring_engine
   import cordic_vectoring_engine_pkg::*;
#(
   parameter int N_ITER = 24,
   parameter int IW     = 34
) (
   input logic clk,
   input logic rst_n,
   cordic_vectoring_engine_if.slave bus
);

   state_t state;
   state_t state_next;

   logic signed [IW-1:0] x_r;
   logic signed [IW-1:0] y_r;
   logic        [31:0]   z_r;
   logic        [4:0]    iter_cnt;

   logic signed [IW-1:0] x_in_ext;
   logic signed [IW-1:0] y_in_ext;
   logic signed [IW-1:0] x_fold;
   logic signed [IW-1:0] y_fold;
   logic        [31:0]   z_fold;
   logic signed [IW-1:0] x_shr;
   logic signed [IW-1:0] y_shr;
   logic        [31:0]   atan_i;
   logic                 last_iter;
   logic                 vec_zero;
   logic        [31:0]   mag_sat;

   assign x_in_ext  = {{(IW-32){bus.x_in[31]}}, bus.x_in};
   assign y_in_ext  = {{(IW-32){bus.y_in[31]}}, bus.y_in};
   assign x_shr     = x_r >>> iter_cnt;
   assign y_shr     = y_r >>> iter_cnt;
   assign atan_i    = atan_lut(iter_cnt);
   assign last_iter = (iter_cnt == 5'(N_ITER - 1));
   // a zero vector stays zero through every rotation; freezing z keeps its angle at 0
   assign vec_zero  = (x_r == '0) && (y_r == '0);
   // x is non-negative after the fold, so any bit at or above 31 means overflow
   assign mag_sat   = (|x_r[IW-1:31]) ? 32'h7FFF_FFFF : {1'b0, x_r[30:0]};

   assign bus.in_ready = (state == ST_IDLE);

`ifdef CORDIC_GAIN_COMP_EN
   logic [IW+31:0]       gain_prod;
   logic signed [IW-1:0] x_gain;

   assign gain_prod = {32'b0, x_r} * {{IW{1'b0}}, CORDIC_K};
   assign x_gain    = IW'(gain_prod >> 31);
`endif

   cordic_vec_precorrect #(.IW(IW)) u_precorrect (
      .x      (x_r),
      .y      (y_r),
      .x_fold (x_fold),
      .y_fold (y_fold),
      .z_init (z_fold)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next-state sequencing: accept, fold, iterate, (scale), present
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (bus.in_valid) state_next = ST_PRE;
         ST_PRE:  state_next = ST_ITER;
         ST_ITER: begin
            if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
               state_next = ST_GAIN;
`else
               state_next = ST_DONE;
`endif
            end
         end
`ifdef CORDIC_GAIN_COMP_EN
         ST_GAIN: state_next = ST_DONE;
`endif
         ST_DONE: if (bus.out_valid && bus.out_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs; DONE loads the result once, then holds it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r           <= '0;
         y_r           <= '0;
         z_r           <= '0;
         iter_cnt      <= '0;
         bus.mag_out   <= '0;
         bus.angle_out <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  x_r <= x_in_ext;
                  y_r <= y_in_ext;
               end
            end
            ST_PRE: begin
               x_r      <= x_fold;
               y_r      <= y_fold;
               z_r      <= z_fold;
               iter_cnt <= '0;
            end
            ST_ITER: begin
               if (!y_r[IW-1]) begin
                  x_r <= x_r + y_shr;
                  y_r <= y_r - x_shr;
                  if (!vec_zero) z_r <= z_r + atan_i;
               end else begin
                  x_r <= x_r - y_shr;
                  y_r <= y_r + x_shr;
                  z_r <= z_r - atan_i;
               end
               iter_cnt <= iter_cnt + 5'd1;
            end
`ifdef CORDIC_GAIN_COMP_EN
            ST_GAIN: begin
               x_r <= x_gain;
            end
`endif
            ST_DONE: begin
               if (!bus.out_valid) begin
                  bus.mag_out   <= mag_sat;
                  bus.angle_out <= z_r;
                  bus.out_valid <= 1'b1;
               end else if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vectoring_engine.sv
// Directed testbench for cordic_vectoring_engine. Expected values are
// hand-computed; magnitudes depend on CORDIC_GAIN_COMP_EN.
// Angle checks use large vectors: the integer datapath resolves angle only to
// about atan(1/|v|), so tight angle tolerances need |v| near full scale.
module tb_cordic_vectoring_engine;

   localparam int N_ITER = 24;
   localparam int ANG_TOL = 256;
   localparam int BIG_TOL = 4096;
   localparam logic [31:0] A_POS = 32'h4000_0000;
   localparam logic [31:0] A_NEG = 32'hC000_0000;

`ifdef CORDIC_GAIN_COMP_EN
   localparam int LAT = N_ITER + 3;
   localparam logic [31:0] MAG_1000   = 32'd1000;
   localparam logic [31:0] MAG_A      = 32'd1073741824;
   localparam logic [31:0] MAG_AA     = 32'd1518500250;
   localparam int          MAG_AA_TOL = BIG_TOL;
   localparam logic [31:0] MAG_34     = 32'd5;
`else
   localparam int LAT = N_ITER + 2;
   localparam logic [31:0] MAG_1000   = 32'd1647;
   localparam logic [31:0] MAG_A      = 32'd1768195371;
   localparam logic [31:0] MAG_AA     = 32'h7FFF_FFFF;
   localparam int          MAG_AA_TOL = 0;
   localparam logic [31:0] MAG_34     = 32'd8;
`endif

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;
   int   lat;

   cordic_vectoring_engine_if bus();

   cordic_vectoring_engine #(.N_ITER(N_ITER), .IW(34)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act,
                              input logic [31:0] want, input int tol);
      longint d;
      logic   ok;
      d = longint'($signed(act - want));
      if (d < 0) d = -d;
      ok = (d <= longint'(tol));
      tests_run++;
      assert (ok === 1'b1)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: got 0x%08h, want 0x%08h +/- %0d", tag, act, want, tol);
      end
   endtask

   task automatic startVector(input logic [31:0] xv, input logic [31:0] yv);
      @(negedge clk);
      checkOutput("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1, 0);
      bus.x_in     = xv;
      bus.y_in     = yv;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic waitResult(output int cycles);
      cycles = 0;
      while (bus.out_valid !== 1'b1 && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [31:0] xv, input logic [31:0] yv);
      startVector(xv, yv);
      waitResult(lat);
      checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT), 0);
   endtask

   task automatic releaseOutput(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checkOutput({tag, "_valid_drop"}, {31'b0, bus.out_valid}, 32'd0, 0);
      checkOutput({tag, "_in_ready_back"}, {31'b0, bus.in_ready}, 32'd1, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      rst_n         = 1'b0;
      bus.x_in      = '0;
      bus.y_in      = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1, 0);
      checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0, 0);
      checkOutput("rst_mag", bus.mag_out, 32'd0, 0);
      checkOutput("rst_angle", bus.angle_out, 32'd0, 0);
      rst_n = 1'b1;

      // Small vector on the +x axis: magnitude and latency
      applyStimulus("v1000_0", 32'd1000, 32'd0);
      checkOutput("v1000_0_mag", bus.mag_out, MAG_1000, 3);
      releaseOutput("v1000_0");

      // Full-scale axes and diagonals: angle accuracy
      applyStimulus("vA_0", A_POS, 32'd0);
      checkOutput("vA_0_mag", bus.mag_out, MAG_A, BIG_TOL);
      checkOutput("vA_0_angle", bus.angle_out, 32'h0000_0000, ANG_TOL);
      releaseOutput("vA_0");

      applyStimulus("v0_A", 32'd0, A_POS);
      checkOutput("v0_A_angle", bus.angle_out, 32'h2000_0000, ANG_TOL);
      releaseOutput("v0_A");

      applyStimulus("v0_nA", 32'd0, A_NEG);
      checkOutput("v0_nA_angle", bus.angle_out, 32'hE000_0000, ANG_TOL);
      releaseOutput("v0_nA");

      applyStimulus("vnA_0", A_NEG, 32'd0);
      checkOutput("vnA_0_angle", bus.angle_out, 32'h4000_0000, ANG_TOL);
      releaseOutput("vnA_0");

      applyStimulus("vnA_nA", A_NEG, A_NEG);
      checkOutput("vnA_nA_angle", bus.angle_out, 32'hD000_0000, ANG_TOL);
      checkOutput("vnA_nA_mag", bus.mag_out, MAG_AA, MAG_AA_TOL);
      releaseOutput("vnA_nA");

      // Zero vector
      applyStimulus("v0_0", 32'd0, 32'd0);
      checkOutput("v0_0_mag", bus.mag_out, 32'd0, 0);
      checkOutput("v0_0_angle", bus.angle_out, 32'd0, 0);
      releaseOutput("v0_0");

      // Most negative inputs: no internal wrap, magnitude saturates
      applyStimulus("vmin", 32'h8000_0000, 32'h8000_0000);
      checkOutput("vmin_mag", bus.mag_out, 32'h7FFF_FFFF, 0);
      checkOutput("vmin_angle", bus.angle_out, 32'hD000_0000, ANG_TOL);
      releaseOutput("vmin");

      // Back-pressure: result held, new input ignored while busy
      applyStimulus("hold", A_POS, 32'd0);
      bus.x_in     = A_NEG;
      bus.y_in     = A_NEG;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("hold_in_ready", {31'b0, bus.in_ready}, 32'd0, 0);
         checkOutput("hold_out_valid", {31'b0, bus.out_valid}, 32'd1, 0);
         checkOutput("hold_mag", bus.mag_out, MAG_A, BIG_TOL);
         checkOutput("hold_angle", bus.angle_out, 32'h0000_0000, ANG_TOL);
      end
      bus.in_valid = 1'b0;
      releaseOutput("hold");
      @(negedge clk);
      checkOutput("hold_idle_in_ready", {31'b0, bus.in_ready}, 32'd1, 0);
      checkOutput("hold_idle_out_valid", {31'b0, bus.out_valid}, 32'd0, 0);

      // Reset pulse during iteration aborts and clears outputs at once
      startVector(A_NEG, 32'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0, 0);
      checkOutput("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1, 0);
      checkOutput("midrst_mag", bus.mag_out, 32'd0, 0);
      checkOutput("midrst_angle", bus.angle_out, 32'd0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("v3_4", 32'd3, 32'd4);
      checkOutput("v3_4_mag", bus.mag_out, MAG_34, 1);
      releaseOutput("v3_4");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
